sum_uart_accum: RTL and testbench
=================================

Name: sum_uart_accum

Overview:
- Parametrised successor of the two-operand latch/add/UART path.
- Captures up to NUM_OPS operands of DATA_W bits from one shared input bus, using an active-low save strobe.
- Keeps a running sum of all captured operands. On request, serialises the snapshot sum as one or more 8N1 UART bytes, LSB byte first.
- Sits between the board switch/button inputs and the UART TX pin.

Parameters:
- DATA_W, 4, operand width in bits (1..16).
- NUM_OPS, 4, maximum number of operands accumulated before saturation of the count (2..16).
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- SUM_W, derived localparam = DATA_W + $clog2(NUM_OPS); sum width, never overflows.
- NBYTES, derived localparam = ceil(SUM_W/8); bytes per transmitted frame.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- data_input  in  DATA_W  operand bus
- save_n  in  1  active-low capture strobe (asynchronous button level)
- clear_n  in  1  active-low accumulator clear (asynchronous button level)
- uart_tx_en  in  1  transmit request (level)
- op_count  out  $clog2(NUM_OPS+1)  operands captured so far
- sum_out  out  SUM_W  current running sum
- full  out  1  op_count == NUM_OPS
- uartbusy  out  1  transmission in progress
- uart_txd  out  1  serial line, idle high

Behaviour:
- Reset values: op_count=0, sum_out=0, full=0, uartbusy=0, uart_txd=1, FSM=IDLE. All sync/edge registers reset to inactive (high for active-low inputs, low for uart_tx_en).
- save_n, clear_n and uart_tx_en each pass through a 2-flop synchroniser plus an edge detector.
  - Events are the falling edge of save_n/clear_n and the rising edge of uart_tx_en, each as a 1-cycle pulse.
  - Pin-to-event latency is 3 clk.
- Save event with full=0: sum_out <= sum_out + zero-extended data_input (synchronised value not required; data sampled on the event cycle). op_count increments. Both update 1 cycle after the event.
- Save event with full=1: ignored; sum and count are unchanged.
- Clear event: sum_out=0 and op_count=0 on the next cycle. If clear and save events occur in the same cycle, clear wins and the operand is dropped.
- Send event while uartbusy=0:
  - snapshot <= sum_out zero-padded to 8*NBYTES; byte index=0; uartbusy=1 the next cycle.
  - Send events while uartbusy=1 are ignored; there is no queueing.
- Accumulation continues during transmission. The snapshot is not affected.
- TX FSM states:
  - IDLE: txd=1; on send event go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: txd=byte[bit], LSB first, 8 bits of CLKS_PER_BIT cycles each, then go to STOP (or PARITY if enabled).
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then, if byte index < NBYTES-1: increment the index and go to START with no idle gap. Otherwise go to IDLE.
- uartbusy deasserts on the cycle the FSM re-enters IDLE. Total busy time = NBYTES*10*CLKS_PER_BIT cycles (11 with parity).
- The bit counter and baud counter wrap to 0 at each bit/byte boundary. There are no partial bits.
- Asynchronous reset mid-frame: txd returns to 1 immediately and the frame is abandoned. The receiver sees a framing error, which is accepted.

Optional Feature:
- Macro SUM_UART_PARITY_EN.
- Defined: a PARITY state is inserted after DATA, sending an even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame becomes 8E1.
- Undefined: 8N1, no PARITY state, and no parity logic is synthesised.

Decomposition:
- Shared package sum_uart_pkg holds:
  - the TX state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - the constant UART_DATA_BITS=8;
  - a clog2-style function for the derived widths.
- One sub-module is natural: uart_byte_tx, a single-byte serializer with start/ready handshake and CLKS_PER_BIT parameter. Its ports are clk, reset_n, start, data[7:0], ready and txd.
- The parent holds the synchronisers, accumulator, snapshot and byte sequencing.

Test Plan (DATA_W=4, NUM_OPS=4, CLKS_PER_BIT=4 unless stated):
- Reset then idle 50 cycles -> uart_txd=1, uartbusy=0, sum_out=0, op_count=0.
- Save 0x3, 0x5, 0xF, 0x9 (save_n low 10 cycles each) -> sum_out=0x20, op_count=4, full=1. A fifth save of 0x7 leaves sum_out at 0x20.
- With sum_out=0x20, pulse uart_tx_en -> uart_txd shows 0, then bits 0,0,0,0,0,1,0,0, then 1, each 4 cycles. uartbusy is high for exactly 40 cycles.
- DATA_W=16, NUM_OPS=2, operands 0xFFFF and 0x0001 -> sum_out=0x10000. Send yields 3 back-to-back bytes 0x00, 0x00, 0x01 with no idle gap and busy for 120 cycles.
- Clear and save falling edges in the same cycle -> sum_out=0, op_count=0. A uart_tx_en re-pulse during busy produces no second frame.
- Assert reset_n low mid-DATA -> uart_txd=1 and uartbusy=0 within the same cycle. With SUM_UART_PARITY_EN, sending 0x07 shows parity bit 1 and busy for 44 cycles.

Source files
------------

// File: rtl/sum_uart_pkg.sv
// Shared types and helpers for the running-sum UART transmitter.
// Optional even parity is selected by SUM_UART_PARITY_EN.
package sum_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int UART_DATA_BITS = 8;

  // Ceiling log2 used for derived widths; clog2_f(1) == 0.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer (8N1, or 8E1 with SUM_UART_PARITY_EN).
// ready is high in IDLE and on the final STOP cycle so bytes can chain back to back.
module uart_byte_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int BAUD_W = clog2_f(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        byte_q, byte_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = START;
      START: if (baud_last) state_d = DATA;
      DATA: begin
        if (baud_last && (bit_q == BIT_LAST)) begin
`ifdef SUM_UART_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SUM_UART_PARITY_EN
      PARITY: if (baud_last) state_d = STOP;
`endif
      // A start on the last stop cycle chains straight into the next start bit.
      STOP: if (baud_last) state_d = start ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd   = 1'b1;
    ready = 1'b0;
    case (state_q)
      IDLE:   ready = 1'b1;
      START:  txd   = 1'b0;
      DATA:   txd   = byte_q[bit_q];
`ifdef SUM_UART_PARITY_EN
      PARITY: txd   = ^byte_q;
`endif
      STOP:   ready = baud_last;
      default: begin
        txd   = 1'b1;
        ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    baud_d = (state_q == IDLE || baud_last) ? '0 : baud_q + BAUD_W'(1);
    bit_d  = bit_q;
    if (state_q != DATA) begin
      bit_d = '0;
    end else if (baud_last) begin
      bit_d = bit_q + 3'd1;
    end
    byte_d = (start && ready) ? data : byte_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_q <= '0;
      bit_q  <= '0;
      byte_q <= '0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
    end
  end

endmodule

// File: rtl/sum_uart_accum.sv
// Operand accumulator with UART readout of the running sum, LSB byte first.
// Define SUM_UART_PARITY_EN for 8E1 frames instead of 8N1.
module sum_uart_accum
  import sum_uart_pkg::*;
#(
  parameter  int DATA_W       = 4,
  parameter  int NUM_OPS      = 4,
  parameter  int CLKS_PER_BIT = 434,
  localparam int SUM_W        = DATA_W + clog2_f(NUM_OPS),
  localparam int CNT_W        = clog2_f(NUM_OPS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              save_n,
  input  logic              clear_n,
  input  logic              uart_tx_en,
  output logic [CNT_W-1:0]  op_count,
  output logic [SUM_W-1:0]  sum_out,
  output logic              full,
  output logic              uartbusy,
  output logic              uart_txd
);

  localparam int NBYTES = (SUM_W + 7) / 8;
  localparam int PAD_W  = 8 * NBYTES;
  localparam int IDX_W  = (NBYTES > 1) ? clog2_f(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Two synchroniser flops plus one history flop per button/request input.
  logic [2:0] save_sh_q, clear_sh_q, txen_sh_q;
  logic       save_evt_q, clear_evt_q, txen_evt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      save_sh_q   <= '1;
      clear_sh_q  <= '1;
      txen_sh_q   <= '0;
      save_evt_q  <= 1'b0;
      clear_evt_q <= 1'b0;
      txen_evt_q  <= 1'b0;
    end else begin
      save_sh_q   <= {save_sh_q[1:0], save_n};
      clear_sh_q  <= {clear_sh_q[1:0], clear_n};
      txen_sh_q   <= {txen_sh_q[1:0], uart_tx_en};
      save_evt_q  <= save_sh_q[2] & ~save_sh_q[1];
      clear_evt_q <= clear_sh_q[2] & ~clear_sh_q[1];
      txen_evt_q  <= ~txen_sh_q[2] & txen_sh_q[1];
    end
  end

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_w;

  assign full_w = (cnt_q == CNT_W'(NUM_OPS));

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clear_evt_q) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (save_evt_q && !full_w) begin
      sum_d = sum_q + SUM_W'(data_input);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  // snap_q holds the bytes of the frozen sum that have not yet been handed to the serializer.
  logic [PAD_W-1:0] sum_pad, snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             tx_ready, tx_start, send_go, next_go, last_done;
  logic [7:0]       tx_data;

  assign sum_pad   = PAD_W'(sum_q);
  assign send_go   = txen_evt_q & ~busy_q;
  assign next_go   = busy_q & tx_ready & (idx_q != LAST_IDX);
  assign last_done = busy_q & tx_ready & (idx_q == LAST_IDX);
  assign tx_start  = send_go | next_go;
  assign tx_data   = send_go ? sum_pad[7:0] : snap_q[7:0];

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (send_go) begin
      busy_d = 1'b1;
      idx_d  = '0;
      snap_d = sum_pad >> 8;
    end else if (next_go) begin
      idx_d  = idx_q + IDX_W'(1);
      snap_d = snap_q >> 8;
    end else if (last_done) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      snap_q <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (tx_start),
    .data   (tx_data),
    .ready  (tx_ready),
    .txd    (uart_txd)
  );

  assign op_count = cnt_q;
  assign sum_out  = sum_q;
  assign full     = full_w;
  assign uartbusy = busy_q;

endmodule

// File: tb/tb_sum_uart_accum.sv
// Randomised bench for sum_uart_accum: two configurations, frames compared against a bit-stream model.
module tb_sum_uart_accum;

  localparam int CPB = 4;
`ifdef SUM_UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_BITS = PAR ? 11 : 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [3:0]  data_a;
  logic        save_a, clear_a, txen_a;
  logic [2:0]  cnt_a;
  logic [5:0]  sum_a;
  logic        full_a, busy_a, txd_a;

  logic [15:0] data_b;
  logic        save_b, clear_b, txen_b;
  logic [1:0]  cnt_b;
  logic [16:0] sum_b;
  logic        full_b, busy_b, txd_b;

  sum_uart_accum #(.DATA_W(4), .NUM_OPS(4), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_input(data_a), .save_n(save_a), .clear_n(clear_a),
    .uart_tx_en(txen_a), .op_count(cnt_a), .sum_out(sum_a), .full(full_a),
    .uartbusy(busy_a), .uart_txd(txd_a));

  sum_uart_accum #(.DATA_W(16), .NUM_OPS(2), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_input(data_b), .save_n(save_b), .clear_n(clear_b),
    .uart_tx_en(txen_b), .op_count(cnt_b), .sum_out(sum_b), .full(full_b),
    .uartbusy(busy_b), .uart_txd(txd_b));

  int   total = 0;
  int   bad   = 0;
  logic cap_q[$];
  logic exp_q[$];

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic get_txd(input int sel);
    return (sel == 0) ? txd_a : txd_b;
  endfunction

  // Expected line level per clock for a whole transmission of 'value', LSB byte first.
  function automatic void build_frame(input logic [31:0] value, input int nbytes);
    exp_q.delete();
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] byt;
      byt = 8'(value >> (8 * b));
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < CPB; k++) exp_q.push_back(byt[i]);
      if (PAR)
        for (int k = 0; k < CPB; k++) exp_q.push_back(^byt);
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
    end
  endfunction

  function automatic int first_diff();
    int m;
    m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic press_save(input int sel, input logic [15:0] v);
    if (sel == 0) begin data_a = v[3:0]; save_a = 1'b0; end
    else          begin data_b = v;      save_b = 1'b0; end
    repeat (10) @(negedge clk);
    if (sel == 0) save_a = 1'b1; else save_b = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic press_clear(input int sel);
    if (sel == 0) clear_a = 1'b0; else clear_b = 1'b0;
    repeat (10) @(negedge clk);
    if (sel == 0) clear_a = 1'b1; else clear_b = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Raises the request, records txd for every busy cycle; optional re-request mid-frame.
  task automatic capture(input int sel, input bit repulse, output int n_busy, output bit rose);
    int w;
    w = 0;
    n_busy = 0;
    cap_q.delete();
    if (sel == 0) txen_a = 1'b1; else txen_b = 1'b1;
    while (!get_busy(sel) && w < 30) begin
      @(negedge clk);
      w++;
    end
    rose = get_busy(sel);
    while (get_busy(sel) && n_busy < 400) begin
      cap_q.push_back(get_txd(sel));
      n_busy++;
      if (repulse && n_busy == 5)  txen_a = 1'b0;
      if (repulse && n_busy == 12) txen_a = 1'b1;
      @(negedge clk);
    end
    if (sel == 0) txen_a = 1'b0; else txen_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    data_a = '0; save_a = 1'b1; clear_a = 1'b1; txen_a = 1'b0;
    data_b = '0; save_b = 1'b1; clear_b = 1'b1; txen_b = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    total++; if (txd_a !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b required 1", txd_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    total++; if (sum_a !== 6'd0) begin bad++; $display("FAIL reset_sum: got %0h required 0", sum_a); end
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", cnt_a); end
    total++; if (full_a !== 1'b0) begin bad++; $display("FAIL reset_full: got %b required 0", full_a); end
    total++; if (txd_b !== 1'b1) begin bad++; $display("FAIL reset_txd_b: got %b required 1", txd_b); end
    total++; if (sum_b !== 17'd0) begin bad++; $display("FAIL reset_sum_b: got %0h required 0", sum_b); end
  endtask

  task automatic test_accumulate();
    logic [3:0]  ops [5];
    logic [31:0] msum;
    int          mcnt;
    ops = '{4'h3, 4'h5, 4'hF, 4'h9, 4'h7};
    msum = 0;
    mcnt = 0;
    for (int i = 0; i < 5; i++) begin
      press_save(0, {12'h0, ops[i]});
      if (mcnt < 4) begin
        msum = msum + ops[i];
        mcnt++;
      end
      total++; if (32'(sum_a) !== msum) begin bad++; $display("FAIL acc_sum[%0d]: got %0h required %0h", i, sum_a, msum); end
      total++; if (32'(cnt_a) !== 32'(mcnt)) begin bad++; $display("FAIL acc_count[%0d]: got %0d required %0d", i, cnt_a, mcnt); end
    end
    total++; if (sum_a !== 6'h20) begin bad++; $display("FAIL acc_final_sum: got %0h required 20", sum_a); end
    total++; if (full_a !== 1'b1) begin bad++; $display("FAIL acc_full: got %b required 1", full_a); end
  endtask

  task automatic test_send();
    int n;
    bit rose;
    int d;
    build_frame(32'h20, 1);
    capture(0, 1'b0, n, rose);
    d = first_diff();
    total++; if (rose !== 1'b1) begin bad++; $display("FAIL send20_busy_rise: got %b required 1", rose); end
    total++; if (n !== FRAME_BITS * CPB) begin bad++; $display("FAIL send20_busy_len: got %0d required %0d", n, FRAME_BITS * CPB); end
    total++; if (d !== -1) begin bad++; $display("FAIL send20_bits: sample %0d got %b required %b", d, cap_q[d], exp_q[d]); end
    press_clear(0);
    press_save(0, 16'h7);
    build_frame(32'h07, 1);
    capture(0, 1'b0, n, rose);
    d = first_diff();
    total++; if (n !== FRAME_BITS * CPB) begin bad++; $display("FAIL send07_busy_len: got %0d required %0d", n, FRAME_BITS * CPB); end
    total++; if (d !== -1) begin bad++; $display("FAIL send07_bits: sample %0d got %b required %b", d, cap_q[d], exp_q[d]); end
  endtask

  task automatic test_multibyte();
    int n;
    bit rose;
    int d;
    press_save(1, 16'hFFFF);
    press_save(1, 16'h0001);
    total++; if (sum_b !== 17'h10000) begin bad++; $display("FAIL mb_sum: got %0h required 10000", sum_b); end
    total++; if (cnt_b !== 2'd2) begin bad++; $display("FAIL mb_count: got %0d required 2", cnt_b); end
    total++; if (full_b !== 1'b1) begin bad++; $display("FAIL mb_full: got %b required 1", full_b); end
    build_frame(32'h10000, 3);
    capture(1, 1'b0, n, rose);
    d = first_diff();
    total++; if (n !== 3 * FRAME_BITS * CPB) begin bad++; $display("FAIL mb_busy_len: got %0d required %0d", n, 3 * FRAME_BITS * CPB); end
    total++; if (d !== -1) begin bad++; $display("FAIL mb_bits: sample %0d got %b required %b", d, cap_q[d], exp_q[d]); end
  endtask

  task automatic test_clear_collision();
    int n;
    bit rose;
    int d;
    int extra;
    press_save(0, 16'h5);
    data_a = 4'hA;
    save_a = 1'b0;
    clear_a = 1'b0;
    repeat (10) @(negedge clk);
    save_a = 1'b1;
    clear_a = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (sum_a !== 6'd0) begin bad++; $display("FAIL coll_sum: got %0h required 0", sum_a); end
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL coll_count: got %0d required 0", cnt_a); end
    build_frame(32'h0, 1);
    capture(0, 1'b1, n, rose);
    d = first_diff();
    total++; if (n !== FRAME_BITS * CPB) begin bad++; $display("FAIL repulse_busy_len: got %0d required %0d", n, FRAME_BITS * CPB); end
    total++; if (d !== -1) begin bad++; $display("FAIL repulse_bits: sample %0d got %b required %b", d, cap_q[d], exp_q[d]); end
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_a) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL repulse_second_frame: busy cycles %0d required 0", extra); end
  endtask

  task automatic test_random();
    logic [31:0] msum;
    logic [3:0]  v;
    int          mcnt, nops, n, d;
    bit          rose;
    for (int r = 0; r < 6; r++) begin
      press_clear(0);
      msum = 0;
      mcnt = 0;
      nops = $urandom_range(1, 6);
      for (int i = 0; i < nops; i++) begin
        v = 4'($urandom_range(0, 15));
        press_save(0, {12'h0, v});
        if (mcnt < 4) begin
          msum = msum + v;
          mcnt++;
        end
      end
      total++; if (32'(sum_a) !== msum) begin bad++; $display("FAIL rnd_sum[%0d]: got %0h required %0h", r, sum_a, msum); end
      total++; if (32'(cnt_a) !== 32'(mcnt)) begin bad++; $display("FAIL rnd_count[%0d]: got %0d required %0d", r, cnt_a, mcnt); end
      total++; if (full_a !== (mcnt == 4)) begin bad++; $display("FAIL rnd_full[%0d]: got %b required %b", r, full_a, (mcnt == 4)); end
      build_frame(msum, 1);
      capture(0, 1'b0, n, rose);
      d = first_diff();
      total++; if (n !== FRAME_BITS * CPB) begin bad++; $display("FAIL rnd_busy_len[%0d]: got %0d required %0d", r, n, FRAME_BITS * CPB); end
      total++; if (d !== -1) begin bad++; $display("FAIL rnd_bits[%0d]: sample %0d got %b required %b", r, d, cap_q[d], exp_q[d]); end
    end
  endtask

  task automatic test_reset_midframe();
    int w;
    press_clear(0);
    press_save(0, 16'hA);
    txen_a = 1'b1;
    w = 0;
    while (!busy_a && w < 30) begin
      @(negedge clk);
      w++;
    end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_busy_rise: got %b required 1", busy_a); end
    repeat (CPB + 1) @(negedge clk);
    total++; if (txd_a !== 1'b0) begin bad++; $display("FAIL mid_data_bit0: got %b required 0", txd_a); end
    reset_n = 1'b0;
    #1;
    total++; if (txd_a !== 1'b1) begin bad++; $display("FAIL mid_reset_txd: got %b required 1", txd_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b required 0", busy_a); end
    total++; if (sum_a !== 6'd0) begin bad++; $display("FAIL mid_reset_sum: got %0h required 0", sum_a); end
    txen_a = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_send();
    test_multibyte();
    test_clear_collision();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
